// File: rtl/slifo_arb.sv
// ============================================================================
// Module   : slifo_arb
// Purpose  : Arbitrates NUM_REQ requesters onto one shared LIFO and returns
//            registered pop-data / error responses.
//            SLIFO_ARB_PRIO_EN selects fixed priority instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slifo_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          rsp_op,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          lifo_wr,
  output logic                          lifo_rd,
  output logic [DATA_WIDTH-1:0]         lifo_din,
  input  logic [DATA_WIDTH-1:0]         lifo_dout,
  input  logic                          lifo_full,
  input  logic                          lifo_empty
);

  logic                  w_any;
  logic                  w_go;
  logic [ID_WIDTH-1:0]   w_win;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_op;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_wdata;
  int                    w_dist;
  int                    w_best;

  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic                  r_rsp_op;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_data;

`ifdef SLIFO_ARB_PRIO_EN
  // Distance equals the index, so the lowest requesting index always wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_dist = 0;
    w_best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = ID_WIDTH'(i);
        w_any  = 1'b1;
      end
    end
  end
`else
  logic [ID_WIDTH-1:0] r_last;

  // Winner is the requester closest after r_last in circular order.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_dist = 0;
    w_best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i - int'(r_last) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = ID_WIDTH'(i);
        w_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= ID_WIDTH'(NUM_REQ - 1);
    end else if (w_go) begin
      r_last <= w_win;
    end
  end
`endif

  // Reset gates the combinational grant path as well as the registers.
  assign w_go = rst_n & w_any;

  always_comb begin
    w_gnt   = '0;
    w_op    = 1'b0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt[i] = w_go && (w_win == ID_WIDTH'(i));
      if (w_gnt[i]) begin
        w_op    = op[i];
        w_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_err    = w_op ? lifo_empty : lifo_full;
  assign gnt      = w_gnt;
  assign lifo_wr  = w_go & ~w_op & ~lifo_full;
  assign lifo_rd  = w_go &  w_op & ~lifo_empty;
  assign lifo_din = lifo_wr ? w_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_op    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_go) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_win;
      r_rsp_op    <= w_op;
      r_rsp_err   <= w_err;
      r_rsp_data  <= lifo_rd ? lifo_dout : '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_op    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_op    = r_rsp_op;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_slifo_arb.sv
// ============================================================================
// Module   : tb_slifo_arb
// Purpose  : Directed self-checking bench for slifo_arb with a depth-4 LIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slifo_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  op;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_op;
  logic        rsp_err;
  logic [7:0]  rsp_data;
  logic        lifo_wr;
  logic        lifo_rd;
  logic [7:0]  lifo_din;
  logic [7:0]  lifo_dout;
  logic        lifo_full;
  logic        lifo_empty;

  slifo_arb #(.NUM_REQ(4), .DATA_WIDTH(8), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .wdata(wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_op(rsp_op),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .lifo_wr(lifo_wr),
    .lifo_rd(lifo_rd), .lifo_din(lifo_din), .lifo_dout(lifo_dout),
    .lifo_full(lifo_full), .lifo_empty(lifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Depth-4 LIFO environment, driven only by the DUT strobes.
  logic [7:0] mem [4];
  int sp = 0;
  always @(posedge clk) begin
    if (lifo_wr && sp < 4) begin
      mem[sp] <= lifo_din;
      sp      <= sp + 1;
    end else if (lifo_rd && sp > 0) begin
      sp <= sp - 1;
    end
  end
  always_comb begin
    lifo_full  = (sp == 4);
    lifo_empty = (sp == 0);
    lifo_dout  = (sp > 0) ? mem[sp-1] : 8'h00;
  end

  typedef struct {
    logic [1:0] id;
    logic       op;
    logic       err;
    logic [7:0] data;
  } rsp_t;

  rsp_t       q[$];
  logic [7:0] exp_stk [4];
  int         exp_sp   = 0;
  int         exp_last = 3;
  int         n_cmp    = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int arb(input logic [3:0] r, input int last);
`ifdef SLIFO_ARB_PRIO_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
    return -1;
  endfunction

  task automatic check_rsp();
    rsp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_id",    rsp_id,    e.id);
      check("rsp_op",    rsp_op,    e.op);
      check("rsp_err",   rsp_err,   e.err);
      check("rsp_data",  rsp_data,  e.data);
    end else begin
      check("rsp_idle", rsp_valid, 1'b0);
    end
  endtask

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic cycle(input logic [3:0] r, input logic [3:0] o, input logic [31:0] wd);
    int         w;
    rsp_t       e;
    logic [3:0] eg;
    logic       ewr, erd;
    logic [7:0] edin;
    req = r; op = o; wdata = wd;
    #3;
    w = arb(r, exp_last);
    eg = '0; ewr = 1'b0; erd = 1'b0; edin = '0;
    if (w >= 0) begin
      eg[w]  = 1'b1;
      e.id   = w[1:0];
      e.op   = o[w];
      e.data = '0;
      if (!o[w]) begin
        e.err = (exp_sp == 4);
        ewr   = !e.err;
        if (ewr) begin
          edin = wd[w*8 +: 8];
          exp_stk[exp_sp] = edin;
          exp_sp++;
        end
      end else begin
        e.err = (exp_sp == 0);
        erd   = !e.err;
        if (erd) begin
          exp_sp--;
          e.data = exp_stk[exp_sp];
        end
      end
      exp_last = w;
      q.push_back(e);
    end
    check("gnt",      gnt,      eg);
    check("lifo_wr",  lifo_wr,  ewr);
    check("lifo_rd",  lifo_rd,  erd);
    check("lifo_din", lifo_din, edin);
    @(posedge clk);
    #1;
    check_rsp();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    wdata = '0;
    #12;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_id",    rsp_id,    2'd0);
    check("reset_rsp_op",    rsp_op,    1'b0);
    check("reset_rsp_err",   rsp_err,   1'b0);
    check("reset_rsp_data",  rsp_data,  8'h00);
    check("reset_gnt",       gnt,       4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four push into an empty LIFO, fifth grant hits full.
    repeat (5) cycle(4'b1111, 4'b0000, 32'hD3D2D1D0);
    // Push on full from requester 2.
    cycle(4'b0100, 4'b0000, 32'h00AA0000);
    // Drain by requester 3, then pop on empty from requester 1.
    repeat (4) cycle(4'b1000, 4'b1000, 32'h0);
    cycle(4'b0010, 4'b0010, 32'h0);
    // Push 0x11, 0x22 then pop twice.
    cycle(4'b0001, 4'b0000, 32'h00000011);
    cycle(4'b0010, 4'b0000, 32'h00002200);
    cycle(4'b1000, 4'b1000, 32'h0);
    cycle(4'b1000, 4'b1000, 32'h0);
    // last=0, then requesters 0 and 3 held.
    cycle(4'b0001, 4'b0000, 32'h00000033);
    repeat (4) cycle(4'b1001, 4'b1001, 32'h0);
    cycle(4'b0000, 4'b0000, 32'h0);

    // Reset while a response is showing and a request is pending.
    cycle(4'b0001, 4'b0000, 32'h00000044);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", rsp_valid, 1'b0);
    check("midreset_rsp_id",    rsp_id,    2'd0);
    check("midreset_gnt",       gnt,       4'b0000);
    check("midreset_lifo_wr",   lifo_wr,   1'b0);
    exp_last = 3;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b1111, 4'b0000, 32'h57565554);
    cycle(4'b0000, 4'b0000, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
